// File: rtl/mcy_lockstep_checker.sv
// Lockstep comparator between a mutated and a golden cv32e40p core: reports the first
// divergence (cycle + field mask), a clean finish (both asleep) or a timeout.
module mcy_lockstep_checker #(
   parameter int unsigned MAX_CYCLES   = 100000,
   parameter int unsigned SLEEP_CYCLES = 16
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_i,
   input  logic        clear_i,
   input  logic [7:0]  mutsel_i,
   input  logic        ref_instr_req_i,
   input  logic        mut_instr_req_i,
   input  logic [31:0] ref_instr_addr_i,
   input  logic [31:0] mut_instr_addr_i,
   input  logic        ref_data_req_i,
   input  logic        mut_data_req_i,
   input  logic        ref_data_we_i,
   input  logic        mut_data_we_i,
   input  logic [3:0]  ref_data_be_i,
   input  logic [3:0]  mut_data_be_i,
   input  logic [31:0] ref_data_addr_i,
   input  logic [31:0] mut_data_addr_i,
   input  logic [31:0] ref_data_wdata_i,
   input  logic [31:0] mut_data_wdata_i,
   input  logic        ref_core_sleep_i,
   input  logic        mut_core_sleep_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        diverged_o,
   output logic        timeout_o,
   output logic [31:0] div_cycle_o,
   output logic [7:0]  div_mask_o,
   output logic [31:0] cycle_cnt_o,
   output logic [7:0]  result_mutsel_o
);

   typedef enum logic [2:0] {IDLE, RUN, DONE, DIVERGED, TIMEOUT} state_t;

   localparam int SW = (SLEEP_CYCLES > 1) ? $clog2(SLEEP_CYCLES) : 1;
   localparam logic [SW-1:0] SLEEP_LAST = SW'(SLEEP_CYCLES - 1);
   localparam logic [31:0]   CYCLE_LAST = 32'(MAX_CYCLES - 1);

   state_t        state_q, state_d;
   logic [SW-1:0] sleep_cnt_q;
   logic [7:0]    mismatch;
   logic          both_ireq, both_dreq, both_we, both_sleep;

   assign both_ireq  = ref_instr_req_i & mut_instr_req_i;
   assign both_dreq  = ref_data_req_i & mut_data_req_i;
   assign both_we    = both_dreq & ref_data_we_i & mut_data_we_i;
   assign both_sleep = ref_core_sleep_i & mut_core_sleep_i;

   // Fields only count when the qualifying request is asserted on both cores.
   assign mismatch[0] = ref_instr_req_i ^ mut_instr_req_i;
   assign mismatch[1] = both_ireq & (ref_instr_addr_i != mut_instr_addr_i);
   assign mismatch[2] = ref_data_req_i ^ mut_data_req_i;
   assign mismatch[3] = both_dreq & (ref_data_we_i != mut_data_we_i);
   assign mismatch[4] = both_dreq & (ref_data_be_i != mut_data_be_i);
   assign mismatch[5] = both_dreq & (ref_data_addr_i != mut_data_addr_i);
   assign mismatch[6] = both_we & (ref_data_wdata_i != mut_data_wdata_i);
   assign mismatch[7] = ref_core_sleep_i ^ mut_core_sleep_i;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // NOTE: state_d gets its default first so no path through the case infers a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start_i && !clear_i) state_d = RUN;
         RUN: begin
            if (clear_i)                                       state_d = IDLE;
            else if (mismatch != 8'd0)                         state_d = DIVERGED;
            else if (both_sleep && sleep_cnt_q == SLEEP_LAST)  state_d = DONE;
            else if (cycle_cnt_o == CYCLE_LAST)                state_d = TIMEOUT;
         end
         default: if (clear_i) state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_o          <= 1'b0;
         done_o          <= 1'b0;
         diverged_o      <= 1'b0;
         timeout_o       <= 1'b0;
         div_cycle_o     <= '0;
         div_mask_o      <= '0;
         cycle_cnt_o     <= '0;
         result_mutsel_o <= '0;
         sleep_cnt_q     <= '0;
      end else begin
         busy_o     <= (state_d == RUN);
         done_o     <= (state_d == DONE);
         diverged_o <= (state_d == DIVERGED);
         timeout_o  <= (state_d == TIMEOUT);
         if (clear_i) begin
            div_cycle_o     <= '0;
            div_mask_o      <= '0;
            cycle_cnt_o     <= '0;
            result_mutsel_o <= '0;
            sleep_cnt_q     <= '0;
         end else begin
            case (state_q)
               IDLE: if (start_i) begin
                  div_cycle_o     <= '0;
                  div_mask_o      <= '0;
                  cycle_cnt_o     <= '0;
                  result_mutsel_o <= mutsel_i;
                  sleep_cnt_q     <= '0;
               end
               RUN: begin
                  if (state_d == DIVERGED) begin
                     div_mask_o  <= mismatch;
                     div_cycle_o <= cycle_cnt_o;
                  end
                  // Terminal transitions freeze the counter at the cycle that ended the run.
                  if (state_d == RUN) cycle_cnt_o <= cycle_cnt_o + 32'd1;
                  if (!both_sleep)              sleep_cnt_q <= '0;
                  else if (sleep_cnt_q != '1)   sleep_cnt_q <= sleep_cnt_q + 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule
